// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage SRAM access controller:
// FSM state encoding, SRAM geometry, and parameter defaults.
package mem_pkg;

   localparam int unsigned SRAM_WAIT_DEF = 2;
   localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

   localparam int unsigned SRAM_ADDR_W = 18;
   localparam int unsigned SRAM_DATA_W = 16;
   localparam int unsigned WAIT_CNT_W  = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOW  = 2'd1;
   localparam logic [1:0] ST_HIGH = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Half-word SRAM address from a 17-bit word offset and the half select.
   function automatic logic [SRAM_ADDR_W-1:0] sram_half_addr(
      input logic [SRAM_ADDR_W-2:0] word_off,
      input logic                   half
   );
      return {word_off, half};
   endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Per-half SRAM wait counter: loadable, decrements to zero and holds there.
module mem_wait_counter
   import mem_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [WAIT_CNT_W-1:0] load_val,
   input  logic                  dec,
   output logic                  zero
);

   logic [WAIT_CNT_W-1:0] count;

   // Load has priority over decrement; the count never wraps below zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller splitting each 32-bit load/store into two 16-bit
// SRAM half-word accesses, freezing the upstream pipeline meanwhile.
// Optional build macro: MEM_ADDR_CHECK_EN enables alignment/range checking
// with a sticky addr_err flag; without it addr_err is tied low.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned SRAM_WAIT = SRAM_WAIT_DEF,
   parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            pc_in,
   input  logic                   wb_en_in,
   input  logic                   mem_read_in,
   input  logic                   mem_write_in,
   input  logic [31:0]            alu_result_in,
   input  logic [31:0]            st_val_in,
   input  logic [4:0]             dest_in,
   output logic [31:0]            pc_out,
   output logic [31:0]            alu_result_out,
   output logic                   wb_en_out,
   output logic                   mem_read_out,
   output logic [4:0]             dest_out,
   output logic [31:0]            mem_data_out,
   output logic                   freeze,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [SRAM_DATA_W-1:0] sram_wdata,
   input  logic [SRAM_DATA_W-1:0] sram_rdata,
   output logic                   sram_we_n,
   output logic                   addr_err
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(SRAM_WAIT - 1);

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic        req;
   logic        rd_op;
   logic        half;
   logic        busy;
   logic        bad_addr;
   logic        fault_done;
   logic        cnt_load;
   logic        cnt_dec;
   logic        cnt_zero;
   logic [16:0] word_off;
   logic [31:0] data;

   assign req   = mem_read_in | mem_write_in;
   // A simultaneous read and write is treated as a write.
   assign rd_op = mem_read_in & ~mem_write_in;
   assign half  = (state == ST_HIGH);
   assign busy  = (state == ST_LOW) || (state == ST_HIGH);

   // Only the low 19 bits of the offset reach the SRAM, so subtract just those.
   assign word_off = 17'((alu_result_in[18:0] - BASE_ADDR[18:0]) >> 2);

`ifdef MEM_ADDR_CHECK_EN
   logic err_q;
   logic addr_err_q;

   assign bad_addr = (alu_result_in[1:0] != 2'b00) ||
                     ((alu_result_in - BASE_ADDR) >= 32'h0008_0000);

   // Track a faulted access through DONE, and latch the sticky fault flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q      <= 1'b0;
         addr_err_q <= 1'b0;
      end else if ((state == ST_IDLE) && req && bad_addr) begin
         err_q      <= 1'b1;
         addr_err_q <= 1'b1;
      end else if (state == ST_DONE) begin
         err_q      <= 1'b0;
      end
   end

   assign fault_done = (state == ST_DONE) && err_q;
   assign addr_err   = addr_err_q;
`else
   assign bad_addr   = 1'b0;
   assign fault_done = 1'b0;
   assign addr_err   = 1'b0;
`endif

   mem_wait_counter u_wait (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (WAIT_LOAD),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // Next-state and wait-counter control.
   always_comb begin
      state_nxt = state;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req) begin
               if (bad_addr) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_LOW;
                  cnt_load  = 1'b1;
               end
            end
         end
         ST_LOW: begin
            if (cnt_zero) begin
               state_nxt = ST_HIGH;
               cnt_load  = 1'b1;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_HIGH: begin
            if (cnt_zero) begin
               state_nxt = ST_DONE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Capture each load half-word on the last wait cycle of its half.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data <= '0;
      end else if (rd_op && cnt_zero) begin
         if (state == ST_LOW) begin
            data[15:0] <= sram_rdata;
         end else if (state == ST_HIGH) begin
            data[31:16] <= sram_rdata;
         end
      end
   end

   // Freeze is gated by reset so an abort drops the stall in the same cycle.
   assign freeze = rst && (((state == ST_IDLE) && req) || busy);

   assign sram_addr  = sram_half_addr(word_off, half);
   assign sram_wdata = half ? st_val_in[31:16] : st_val_in[15:0];
   assign sram_we_n  = ~(mem_write_in && busy);

   assign pc_out         = pc_in;
   assign alu_result_out = alu_result_in;
   assign dest_out       = dest_in;
   assign mem_read_out   = rd_op;
   // MEM/WB keeps clocking while frozen; suppress writeback until the
   // instruction retires so it is written back exactly once.
   assign wb_en_out      = wb_en_in && !freeze && !fault_done;
   assign mem_data_out   = fault_done ? '0 : data;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed instructions push expected
// retire records and SRAM write beats; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in, alu_result_in, st_val_in;
   logic        wb_en_in, mem_read_in, mem_write_in;
   logic [4:0]  dest_in;
   logic [31:0] pc_out, alu_result_out, mem_data_out;
   logic        wb_en_out, mem_read_out, freeze, sram_we_n, addr_err;
   logic [4:0]  dest_out;
   logic [17:0] sram_addr;
   logic [15:0] sram_wdata, sram_rdata;

   always #5 clk = ~clk;

   mem_access_ctrl #(.SRAM_WAIT(2), .BASE_ADDR(32'd1024)) dut (
      .clk(clk), .rst(rst),
      .pc_in(pc_in), .wb_en_in(wb_en_in), .mem_read_in(mem_read_in),
      .mem_write_in(mem_write_in), .alu_result_in(alu_result_in),
      .st_val_in(st_val_in), .dest_in(dest_in),
      .pc_out(pc_out), .alu_result_out(alu_result_out), .wb_en_out(wb_en_out),
      .mem_read_out(mem_read_out), .dest_out(dest_out),
      .mem_data_out(mem_data_out), .freeze(freeze),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .sram_we_n(sram_we_n), .addr_err(addr_err)
   );

   // Small SRAM model (low 10 address bits).
   logic [15:0] sram_mem [0:1023];
   assign sram_rdata = sram_mem[sram_addr[9:0]];
   always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr[9:0]] <= sram_wdata;

   typedef struct {
      logic [31:0] pc, alu, data;
      logic [4:0]  dest;
      logic        wb, rd, chk_data;
   } ret_t;
   typedef struct {
      logic [17:0] addr;
      logic [15:0] wdata;
   } beat_t;

   ret_t  ret_q[$];
   beat_t beat_q[$];
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   logic instr_active = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_beat(input logic [17:0] a, input logic [15:0] d);
      beat_t b;
      b.addr = a; b.wdata = d;
      beat_q.push_back(b);
   endtask

   // Monitor: retire records when an instruction leaves MEM, beats on strobes.
   always @(negedge clk) begin : monitor
      ret_t  e;
      beat_t b;
      if (rst && instr_active && !freeze) begin
         if (ret_q.size() == 0) begin
            check("retire_unexpected", 32'd1, 32'd0);
         end else begin
            e = ret_q.pop_front();
            check("ret_pc",   pc_out,         e.pc);
            check("ret_alu",  alu_result_out, e.alu);
            check("ret_dest", {27'd0, dest_out}, {27'd0, e.dest});
            check("ret_wb",   {31'd0, wb_en_out},    {31'd0, e.wb});
            check("ret_rd",   {31'd0, mem_read_out}, {31'd0, e.rd});
            if (e.chk_data) check("ret_data", mem_data_out, e.data);
         end
      end
      if (rst && !sram_we_n) begin
         if (beat_q.size() == 0) begin
            check("beat_unexpected", {14'd0, sram_addr}, 32'hFFFF_FFFF);
         end else begin
            b = beat_q.pop_front();
            check("beat_addr",  {14'd0, sram_addr},  {14'd0, b.addr});
            check("beat_wdata", {16'd0, sram_wdata}, {16'd0, b.wdata});
         end
      end
   end

   task automatic bubble();
      pc_in = '0; wb_en_in = 0; mem_read_in = 0; mem_write_in = 0;
      alu_result_in = '0; st_val_in = '0; dest_in = '0;
   endtask

   // Present one instruction (called at posedge+1), hold it until retire.
   task automatic issue(input string name, input logic [31:0] pc,
                        input logic wb, input logic rd, input logic wr,
                        input logic [31:0] alu, input logic [31:0] st,
                        input logic [4:0] dest, input logic exp_wb,
                        input logic exp_rd, input logic chk,
                        input logic [31:0] exp_data, input int unsigned exp_freeze);
      ret_t r;
      int unsigned nf;
      r.pc = pc; r.alu = alu; r.dest = dest; r.wb = exp_wb; r.rd = exp_rd;
      r.chk_data = chk; r.data = exp_data;
      ret_q.push_back(r);
      pc_in = pc; wb_en_in = wb; mem_read_in = rd; mem_write_in = wr;
      alu_result_in = alu; st_val_in = st; dest_in = dest;
      instr_active = 1'b1;
      nf = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (freeze) nf++;
         else break;
      end
      check({name, "_freeze_cycles"}, nf, exp_freeze);
      @(posedge clk);
      #1;
      instr_active = 1'b0;
      bubble();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      bubble();
      #12;
      check("rst_freeze",   {31'd0, freeze},    32'd0);
      check("rst_we_n",     {31'd0, sram_we_n}, 32'd1);
      check("rst_addr_err", {31'd0, addr_err},  32'd0);
      check("rst_data",     mem_data_out,       32'd0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;

      // ALU op: zero latency passthrough
      issue("add", 32'h100, 1, 0, 0, 32'h1234_5678, 32'h0, 5'd3, 1, 0, 0, 32'h0, 0);

      // Store DEADBEEF to 1028 -> word 1, half-addrs 2/3
      push_beat(18'd2, 16'hBEEF); push_beat(18'd2, 16'hBEEF);
      push_beat(18'd3, 16'hDEAD); push_beat(18'd3, 16'hDEAD);
      issue("store1", 32'h104, 0, 0, 1, 32'd1028, 32'hDEAD_BEEF, 5'd0, 0, 0, 0, 32'h0, 5);

      issue("load1", 32'h108, 1, 1, 0, 32'd1028, 32'h0, 5'd5, 1, 1, 1, 32'hDEAD_BEEF, 5);

      // Back-to-back load then store to 1032 -> half-addrs 4/5
      issue("load2", 32'h10C, 1, 1, 0, 32'd1028, 32'h0, 5'd6, 1, 1, 1, 32'hDEAD_BEEF, 5);
      push_beat(18'd4, 16'hF00D); push_beat(18'd4, 16'hF00D);
      push_beat(18'd5, 16'hCAFE); push_beat(18'd5, 16'hCAFE);
      issue("store2", 32'h110, 0, 0, 1, 32'd1032, 32'hCAFE_F00D, 5'd0, 0, 0, 0, 32'h0, 5);
      issue("load3", 32'h114, 1, 1, 0, 32'd1032, 32'h0, 5'd7, 1, 1, 1, 32'hCAFE_F00D, 5);

      // Read+write together is a write; mem_read_out forced low
      push_beat(18'd6, 16'hC0DE); push_beat(18'd6, 16'hC0DE);
      push_beat(18'd7, 16'h0BAD); push_beat(18'd7, 16'h0BAD);
      issue("rdwr", 32'h118, 0, 1, 1, 32'd1036, 32'h0BAD_C0DE, 5'd0, 0, 0, 0, 32'h0, 5);
      issue("load4", 32'h11C, 1, 1, 0, 32'd1036, 32'h0, 5'd8, 1, 1, 1, 32'h0BAD_C0DE, 5);
      // Load data held while a non-memory op passes
      issue("hold", 32'h120, 1, 0, 0, 32'h0000_0042, 32'h0, 5'd9, 1, 0, 1, 32'h0BAD_C0DE, 0);

      // Last word of the window: offset 0x7FFFC -> half-addrs 0x3FFFE/0x3FFFF
      push_beat(18'h3FFFE, 16'hA5A5); push_beat(18'h3FFFE, 16'hA5A5);
      push_beat(18'h3FFFF, 16'h5A5A); push_beat(18'h3FFFF, 16'h5A5A);
      issue("store_top", 32'h124, 0, 0, 1, 32'd1024 + 32'h7FFFC, 32'h5A5A_A5A5,
            5'd0, 0, 0, 0, 32'h0, 5);

      // Reset pulse during HIGH aborts the store (1040 -> half-addrs 8/9)
      push_beat(18'd8, 16'h5678); push_beat(18'd8, 16'h5678);
      push_beat(18'd9, 16'h1234);
      pc_in = 32'h128; mem_write_in = 1; alu_result_in = 32'd1040;
      st_val_in = 32'h1234_5678;
      repeat (4) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("abort_freeze", {31'd0, freeze},    32'd0);
      check("abort_we_n",   {31'd0, sram_we_n}, 32'd1);
      check("abort_data",   mem_data_out,       32'd0);
      bubble();
      #3 rst = 1'b1;
      @(posedge clk); #1;
      check("abort_idle_freeze", {31'd0, freeze}, 32'd0);
      issue("load5", 32'h12C, 1, 1, 0, 32'd1028, 32'h0, 5'd10, 1, 1, 1, 32'hDEAD_BEEF, 5);

`ifdef MEM_ADDR_CHECK_EN
      check("pre_addr_err", {31'd0, addr_err}, 32'd0);
      issue("load_misal", 32'h130, 1, 1, 0, 32'd1030, 32'h0, 5'd11, 0, 1, 1, 32'h0, 1);
      check("addr_err_set", {31'd0, addr_err}, 32'd1);
      issue("store_low", 32'h134, 0, 0, 1, 32'd1020, 32'hFFFF_FFFF, 5'd0, 0, 0, 0, 32'h0, 1);
      issue("load_ok", 32'h138, 1, 1, 0, 32'd1028, 32'h0, 5'd12, 1, 1, 1, 32'hDEAD_BEEF, 5);
      check("addr_err_sticky", {31'd0, addr_err}, 32'd1);
`else
      issue("load_misal", 32'h130, 1, 1, 0, 32'd1030, 32'h0, 5'd11, 1, 1, 1, 32'hDEAD_BEEF, 5);
      check("addr_err_tied", {31'd0, addr_err}, 32'd0);
`endif

      repeat (3) @(negedge clk);
      check("ret_q_empty",  ret_q.size(),  32'd0);
      check("beat_q_empty", beat_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter SRAM_WAIT, default 2: clock cycles per 16-bit SRAM half-word access; legal range 1..15.
REQ-002 Parameter BASE_ADDR, default 32'd1024: byte address mapped to SRAM word 0.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 pc_in  in  32  PC from EXE/MEM register.
REQ-007 wb_en_in, mem_read_in, mem_write_in  in  1 each  control bits from EXE/MEM.
REQ-008 alu_result_in  in  32  byte address (loads and stores) or ALU result (other instructions).
REQ-009 st_val_in  in  32  store data.
REQ-010 dest_in  in  5  destination register.
REQ-011 pc_out, alu_result_out  out  32  passthrough to MEM/WB.
REQ-012 wb_en_out, mem_read_out  out  1  passthrough to MEM/WB.
REQ-013 dest_out  out  5  passthrough to MEM/WB.
REQ-014 mem_data_out  out  32  assembled load data.
REQ-015 freeze  out  1  stalls the IF, ID, EXE stages and the IF/ID, ID/EXE, EXE/MEM registers while high.
REQ-016 sram_addr  out  18  half-word address = {(alu_result_in - BASE_ADDR)[18:2], half}.
REQ-017 sram_wdata  out  16  write data.
REQ-018 sram_rdata  in  16  read data.
REQ-019 sram_we_n  out  1  active-low write strobe.
REQ-020 addr_err  out  1  sticky address fault flag (see Configuration).

Function
REQ-021 FSM states: IDLE, LOW, HIGH, DONE.
REQ-022 IDLE with mem_read_in or mem_write_in high: freeze is asserted combinationally in the same cycle; wait counter loads SRAM_WAIT-1; next state is LOW.
REQ-023 IDLE with neither request: all passthrough outputs follow their inputs combinationally; freeze=0; zero added latency.
REQ-024 LOW: half=0 for SRAM_WAIT cycles; on a write, sram_wdata=st_val_in[15:0] and sram_we_n=0; on a read, sram_rdata is captured into data[15:0] on the final LOW cycle; next state is HIGH.
REQ-025 HIGH: same as LOW, with half=1 and bits [31:16]; next state is DONE.
REQ-026 DONE: freeze=0 for exactly one cycle; mem_data_out is valid; next state is IDLE unconditionally, so the same instruction is never re-issued.
REQ-027 Memory op timing: total 2*SRAM_WAIT+2 cycles; freeze high for 2*SRAM_WAIT+1 cycles.
REQ-028 mem_read_in and mem_write_in both high: treated as a write; mem_read_out is forced to 0.
REQ-029 sram_we_n is 1 in IDLE and DONE; no write strobe is ever driven across a half boundary without one cycle of address stability.
REQ-030 mem_data_out holds its last load value outside DONE.

Reset
REQ-031 When rst=0, asynchronously: state=IDLE, counter=0, data=0, freeze=0, sram_we_n=1, addr_err=0.
REQ-032 Reset during LOW or HIGH aborts the access; a partial write may remain in SRAM; no retry occurs.

Configuration
REQ-033 Macro MEM_ADDR_CHECK_EN defined: an access with a misaligned address (bits [1:0] != 0) or an address outside [BASE_ADDR, BASE_ADDR+2^19) skips LOW/HIGH and goes IDLE->DONE with no SRAM strobe.
REQ-034 In that case (MEM_ADDR_CHECK_EN defined): mem_data_out=0, wb_en_out=0, and addr_err sets and stays set until reset.
REQ-035 Macro undefined: no checks; the address is truncated per REQ-016; addr_err is tied 0.

Structure
REQ-036 Shared package mem_pkg holds the FSM state encoding, BASE_ADDR default, SRAM address and data width constants, and the SRAM_WAIT default.
REQ-037 One sub-module, mem_wait_counter (load, decrement, zero flag), provides the per-half wait timing.

Verification
REQ-038 Add (mem_read=0, mem_write=0) -> freeze stays 0; outputs equal inputs in the same cycle.
REQ-039 Store 32'hDEADBEEF to 1028, SRAM_WAIT=2 -> sram_addr=2 with wdata=BEEF for 2 cycles, then addr 3 with DEAD for 2 cycles; freeze high 5 cycles.
REQ-040 Load from 1028 after REQ-039 -> mem_data_out=32'hDEADBEEF in DONE; MEM/WB captures it once.
REQ-041 Back-to-back load then store -> second access starts only in the IDLE cycle after DONE; no lost or duplicated operation.
REQ-042 rst pulse low in HIGH -> state IDLE, freeze 0, sram_we_n 1 within the same cycle.
REQ-043 MEM_ADDR_CHECK_EN, load from 1030 -> no strobe, DONE after 1 cycle, addr_err=1, wb_en_out=0.
